// File: rtl/stream_mux_rr_pkg.sv
// Shared types and constants for the round-robin stream multiplexer.
package stream_mux_pkg;

    // Arbitration state: free to choose a new channel, or locked to one mid-packet.
    typedef enum logic {IDLE, LOCK} smux_state_t;

    // Encoding of the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between producers, the multiplexer and the shared sink.
// The mux side uses the slave modport; the producer/sink side uses master.
interface stream_mux_rr_if #(
    parameter int WIDTH = 12,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [NCH-1:0]        in_valid;
    logic [NCH-1:0]        in_last;
    logic [NCH*WIDTH-1:0]  in_data;
    logic [NCH-1:0]        in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;
    logic [SELW-1:0]       out_ch;
    logic                  out_ready;

    modport master (
        output mode, sel, in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ch
    );

endinterface

// File: rtl/stream_mux_rr_rr_pick.sv
// Rotating-priority encoder: returns the first requesting index found when
// scanning ptr, ptr+1, ... wrapping modulo NCH.
module rr_pick #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]          req,
    input  logic [$clog2(NCH)-1:0]  ptr,
    output logic [$clog2(NCH)-1:0]  gnt_idx,
    output logic                    any
);
    localparam int SELW = $clog2(NCH);

    // Scan all positions starting at ptr; the first hit wins.
    always_comb begin
        logic            found;
        int              idx;
        logic [SELW-1:0] idx_sel;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            idx_sel = SELW'(idx);
            if (!found && req[idx_sel]) begin
                found   = 1'b1;
                gnt_idx = idx_sel;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/stream_mux_rr.sv
// NCH-channel registered stream multiplexer with fixed or round-robin
// channel choice. A channel keeps the grant until its last beat is taken.
module stream_mux_rr #(
    parameter int WIDTH = 12,
    parameter int NCH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    stream_mux_rr_if.slave  bus
);
    import stream_mux_pkg::*;

    localparam int SELW = $clog2(NCH);

    smux_state_t      state_reg, state_next;
    logic [SELW-1:0]  lock_ch_reg, lock_ch_next;
    logic [SELW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic [SELW-1:0]  out_ch_reg;

    logic             load_en;
    logic             grant_ok;
    logic [SELW-1:0]  grant;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [NCH-1:0]   in_ready_vec;
    logic [WIDTH-1:0] ch_data [NCH];
    logic             xfer;
    logic [WIDTH-1:0] beat_data;
    logic             beat_last;

    rr_pick #(.NCH(NCH)) u_pick (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_reg),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // The output register can take a new beat when empty or being drained.
    assign load_en = !out_valid_reg | bus.out_ready;

    // Lock overrides everything; otherwise mode picks fixed select or round-robin.
    always_comb begin
        grant    = rr_idx;
        grant_ok = rr_any;
        if (state_reg == LOCK) begin
            grant    = lock_ch_reg;
            grant_ok = 1'b1;
        end else if (bus.mode == MODE_FIXED) begin
            grant    = bus.sel;
            grant_ok = (int'(bus.sel) < NCH);
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign ch_data[gi]      = bus.in_data[gi*WIDTH +: WIDTH];
            assign in_ready_vec[gi] = load_en & grant_ok & (grant == SELW'(gi));
        end
    endgenerate

    assign bus.in_ready = in_ready_vec;
    assign xfer         = |(bus.in_valid & in_ready_vec);
    assign beat_data    = ch_data[grant];
    assign beat_last    = bus.in_last[grant];

    // Packet lock tracking and round-robin pointer advance on accepted beats.
    always_comb begin
        state_next   = state_reg;
        lock_ch_next = lock_ch_reg;
        rr_ptr_next  = rr_ptr_reg;
        if (xfer) begin
            if (state_reg == IDLE && !beat_last) begin
                state_next   = LOCK;
                lock_ch_next = grant;
            end else if (state_reg == LOCK && beat_last) begin
                state_next = IDLE;
            end
            if (beat_last && bus.mode == MODE_RR) begin
                rr_ptr_next = (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
            end
        end
    end

    // State and output register; an empty or drained slot loads the accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            lock_ch_reg   <= '0;
            rr_ptr_reg    <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_ch_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            lock_ch_reg <= lock_ch_next;
            rr_ptr_reg  <= rr_ptr_next;
            if (load_en) begin
                out_valid_reg <= xfer;
                if (xfer) begin
                    out_data_reg <= beat_data;
                    out_last_reg <= beat_last;
                    out_ch_reg   <= grant;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_ch    = out_ch_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: expected beats are queued as stimulus is
// driven and compared as the sink accepts them.
module tb_stream_mux_rr;
    localparam int WIDTH = 12;
    localparam int NCH   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

    stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [14:0] exp_q [$];
    logic [14:0] mon_got;
    logic [14:0] mon_want;
    logic [11:0] dv [4] = '{12'h000, 12'h555, 12'hAAA, 12'hFFF};
    int          sel_seq [4] = '{1, 0, 2, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [11:0] d0, input logic [11:0] d1,
                            input logic [11:0] d2, input logic [11:0] d3);
        bus.in_data = {d3, d2, d1, d0};
    endtask

    task automatic push(input logic [11:0] d, input logic l, input int c);
        exp_q.push_back({d, l, 2'(c)});
    endtask

    // Let the last loaded beat drain with no new input.
    task automatic drain();
        bus.in_valid = '0;
        @(negedge clk);
        tick();
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    // Sink-side monitor: every accepted beat must match the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                mon_got = {bus.out_data, bus.out_last, bus.out_ch};
                $display("beat ch=%0d data=%h last=%b", bus.out_ch, bus.out_data, bus.out_last);
                if (exp_q.size() == 0) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_beat: observed %h expected none", mon_got);
                    end
                end else begin
                    mon_want = exp_q.pop_front();
                    checks++;
                    assert (mon_got === mon_want) else begin
                        errors++;
                        $error("FAIL beat: observed %h expected %h", mon_got, mon_want);
                    end
                end
            end
        end
    end

    initial begin
        bus.mode      = 1'b0;
        bus.sel       = '0;
        bus.in_valid  = '0;
        bus.in_last   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
        reset = 1'b0;
        tick();

        // 1: fixed select, single-beat packets on every channel
        bus.mode     = 1'b0;
        bus.in_valid = 4'hF;
        bus.in_last  = 4'hF;
        set_data(dv[0], dv[1], dv[2], dv[3]);
        for (int i = 0; i < 4; i++) begin
            bus.sel = 2'(sel_seq[i]);
            push(dv[sel_seq[i]], 1'b1, sel_seq[i]);
            @(negedge clk);
            chk("t1_in_ready", 32'(bus.in_ready), 32'(4'b0001 << sel_seq[i]));
            tick();
            chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        end
        drain();
        chk("t1_hold_data", 32'(bus.out_data), 32'hFFF);
        chk("t1_hold_ch",   32'(bus.out_ch),   32'd3);

        // 2: round-robin over all valid single-beat channels
        bus.mode     = 1'b1;
        bus.in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            push(dv[k % 4], 1'b1, k % 4);
            @(negedge clk);
            chk("t2_in_ready", 32'(bus.in_ready), 32'(4'b0001 << (k % 4)));
            tick();
        end
        drain();

        // 3: ch2 three-beat packet holds the grant, then ch3 is next
        bus.in_valid = 4'b1101;
        bus.in_last  = 4'b1001;
        set_data(12'h000, 12'h555, 12'h111, 12'hFFF);
        push(12'h111, 1'b0, 2);
        @(negedge clk);
        chk("t3_beat1_ready", 32'(bus.in_ready), 32'h4);
        tick();
        set_data(12'h000, 12'h555, 12'h222, 12'hFFF);
        push(12'h222, 1'b0, 2);
        @(negedge clk);
        chk("t3_beat2_ready", 32'(bus.in_ready), 32'h4);
        tick();
        set_data(12'h000, 12'h555, 12'h333, 12'hFFF);
        bus.in_last = 4'b1101;
        push(12'h333, 1'b1, 2);
        @(negedge clk);
        chk("t3_beat3_ready", 32'(bus.in_ready), 32'h4);
        tick();
        push(12'hFFF, 1'b1, 3);
        @(negedge clk);
        chk("t3_next_ch3", 32'(bus.in_ready), 32'h8);
        tick();
        drain();

        // 4: backpressure holds the beat, release loads the next on the same edge
        bus.in_valid = 4'hF;
        bus.in_last  = 4'hF;
        set_data(12'h123, 12'h555, 12'hAAA, 12'hFFF);
        push(12'h123, 1'b1, 0);
        @(negedge clk);
        chk("t4_first_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_ready", 32'(bus.in_ready),  32'h0);
            chk("t4_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_stall_data",  32'(bus.out_data),  32'h123);
            tick();
        end
        bus.out_ready = 1'b1;
        push(12'h555, 1'b1, 1);
        @(negedge clk);
        chk("t4_release_ready", 32'(bus.in_ready), 32'h2);
        tick();
        chk("t4_new_data", 32'(bus.out_data), 32'h555);
        chk("t4_new_ch",   32'(bus.out_ch),   32'd1);
        drain();

        // 5: fixed mode, sel changes mid-packet; ch0 keeps the grant until last
        bus.mode     = 1'b0;
        bus.sel      = 2'd0;
        bus.in_valid = 4'b1001;
        bus.in_last  = 4'b1000;
        set_data(12'h101, 12'h555, 12'hAAA, 12'hFFF);
        push(12'h101, 1'b0, 0);
        @(negedge clk);
        chk("t5_beat1_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.sel = 2'd3;
        set_data(12'h102, 12'h555, 12'hAAA, 12'hFFF);
        push(12'h102, 1'b0, 0);
        @(negedge clk);
        chk("t5_beat2_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 4'b1000;
        @(negedge clk);
        chk("t5_gap_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("t5_gap_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 4'b1001;
        bus.in_last  = 4'b1001;
        set_data(12'h103, 12'h555, 12'hAAA, 12'hFFF);
        push(12'h103, 1'b1, 0);
        @(negedge clk);
        chk("t5_last_ready", 32'(bus.in_ready), 32'h1);
        tick();
        push(12'hFFF, 1'b1, 3);
        @(negedge clk);
        chk("t5_ch3_ready", 32'(bus.in_ready), 32'h8);
        tick();
        drain();

        // 6: reset while locked with a held beat
        bus.mode     = 1'b1;
        bus.in_valid = 4'b0100;
        bus.in_last  = 4'b0000;
        set_data(12'h000, 12'h555, 12'h777, 12'hFFF);
        @(negedge clk);
        chk("t6_lock_ready", 32'(bus.in_ready), 32'h4);
        tick();
        chk("t6_held_valid", 32'(bus.out_valid), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_rst_data",  32'(bus.out_data),  32'd0);
        chk("t6_rst_ch",    32'(bus.out_ch),    32'd0);
        tick();
        bus.in_valid = 4'hF;
        bus.in_last  = 4'hF;
        set_data(dv[0], dv[1], dv[2], dv[3]);
        reset = 1'b0;
        push(12'h000, 1'b1, 0);
        @(negedge clk);
        chk("t6_first_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("t6_first_ch", 32'(bus.out_ch), 32'd0);
        drain();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
